// File: rtl/pixel_block_writer_if.sv
// Pixel stream plus VRAM block load/save bus seen by pixel_block_writer.
// The writer sits on the slave side; the rasteriser/memory model uses master.
interface pixel_block_writer_if #(
  parameter int LANES     = 2,
  parameter int BLOCK_PIX = 16,
  parameter int ADR_W     = 15
);
  localparam int SLOT_W = (BLOCK_PIX / LANES > 1) ? $clog2(BLOCK_PIX / LANES) : 1;
  localparam int DATA_W = 16 * BLOCK_PIX;

  logic [LANES-1:0]     i_pixValid;
  logic [16*LANES-1:0]  i_pixData;
  logic [ADR_W-1:0]     i_blockAdr;
  logic [SLOT_W-1:0]    i_slot;
  logic                 i_needBG;
  logic                 i_flush;
  logic                 o_stall;
  logic [16*LANES-1:0]  o_bgPixels;
  logic                 o_loadReq;
  logic [ADR_W-1:0]     o_loadAdr;
  logic                 i_loadValid;
  logic [DATA_W-1:0]    i_loadData;
  logic                 o_saveReq;
  logic [ADR_W-1:0]     o_saveAdr;
  logic [DATA_W-1:0]    o_saveData;
  logic [BLOCK_PIX-1:0] o_saveMask;
  logic                 i_saveAck;
  logic                 o_idle;

  modport slave (
    input  i_pixValid, i_pixData, i_blockAdr, i_slot, i_needBG, i_flush,
    input  i_loadValid, i_loadData, i_saveAck,
    output o_stall, o_bgPixels, o_loadReq, o_loadAdr,
    output o_saveReq, o_saveAdr, o_saveData, o_saveMask, o_idle
  );

  modport master (
    output i_pixValid, i_pixData, i_blockAdr, i_slot, i_needBG, i_flush,
    output i_loadValid, i_loadData, i_saveAck,
    input  o_stall, o_bgPixels, o_loadReq, o_loadAdr,
    input  o_saveReq, o_saveAdr, o_saveData, o_saveMask, o_idle
  );
endinterface

// File: rtl/pixel_block_writer.sv
// Single-block write-back cache between the pixel pipeline and VRAM: gathers
// lane writes into one block buffer, loading it first when blending needs it.
module pixel_block_writer #(
  parameter int LANES     = 2,
  parameter int BLOCK_PIX = 16,
  parameter int ADR_W     = 15
) (
  input  logic                 clk,
  input  logic                 i_rst,
  pixel_block_writer_if.slave  bus
);
  localparam int DATA_W = 16 * BLOCK_PIX;
  localparam int PIX_W  = (BLOCK_PIX > 1) ? $clog2(BLOCK_PIX) : 1;

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_ACTIVE, S_SAVE} state_t;

  state_t               state_q, state_d;
  logic [ADR_W-1:0]     cur_adr_q, cur_adr_d;
  logic [DATA_W-1:0]    buf_q, buf_d;
  logic [BLOCK_PIX-1:0] dirty_q, dirty_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 present, accept, stall, open_blk;
  logic [PIX_W-1:0]     wr_idx;

  assign present = |bus.i_pixValid;

  always_comb begin
    state_d      = state_q;
    cur_adr_d    = cur_adr_q;
    buf_d        = buf_q;
    dirty_d      = dirty_q;
    flush_pend_d = flush_pend_q;
    accept       = 1'b0;
    stall        = 1'b0;
    open_blk     = 1'b0;
    wr_idx       = '0;

    case (state_q)
      S_EMPTY: open_blk = present;
      S_ACTIVE: begin
        if (present) begin
          if (bus.i_blockAdr == cur_adr_q) begin
            accept = 1'b1;
          end else if (|dirty_q) begin
            stall   = 1'b1;
            state_d = S_SAVE;
          end else begin
            // Clean block: nothing to write back, so reopen in place.
            open_blk = 1'b1;
          end
        end
      end
      S_LOAD: begin
        stall = present;
        if (bus.i_flush) flush_pend_d = 1'b1;
        if (bus.i_loadValid) begin
          buf_d        = bus.i_loadData;
          dirty_d      = '0;
          flush_pend_d = 1'b0;
          state_d      = (flush_pend_q || bus.i_flush) ? S_EMPTY : S_ACTIVE;
        end
      end
      S_SAVE: begin
        stall = present;
        if (bus.i_flush) flush_pend_d = 1'b1;
        if (bus.i_saveAck) begin
          dirty_d      = '0;
          flush_pend_d = 1'b0;
          state_d      = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (open_blk) begin
      cur_adr_d = bus.i_blockAdr;
      if (bus.i_needBG) begin
        stall   = 1'b1;
        state_d = S_LOAD;
      end else begin
        accept  = 1'b1;
        state_d = S_ACTIVE;
      end
    end

    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.i_pixValid[k]) begin
          wr_idx = PIX_W'(int'(bus.i_slot) * LANES + k);
          buf_d[{wr_idx, 4'b0000} +: 16] = bus.i_pixData[16*k +: 16];
          dirty_d[wr_idx] = 1'b1;
        end
      end
    end

    // Flush sees the dirty mask including any pixel accepted on this edge.
    if (bus.i_flush && (state_q == S_EMPTY || state_q == S_ACTIVE)) begin
      if (state_d == S_LOAD) begin
        flush_pend_d = 1'b1;
      end else if (|dirty_d) begin
        flush_pend_d = 1'b1;
        state_d      = S_SAVE;
      end else begin
        state_d = S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= S_EMPTY;
      cur_adr_q    <= '0;
      dirty_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_adr_q    <= cur_adr_d;
      dirty_q      <= dirty_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_bg
    logic [PIX_W-1:0] bg_idx;
    assign bg_idx = PIX_W'(int'(bus.i_slot) * LANES + k);
    assign bus.o_bgPixels[16*k +: 16] = buf_q[{bg_idx, 4'b0000} +: 16];
  end

  assign bus.o_stall    = stall;
  assign bus.o_loadReq  = (state_q == S_LOAD);
  assign bus.o_loadAdr  = cur_adr_q;
  assign bus.o_saveReq  = (state_q == S_SAVE);
  assign bus.o_saveAdr  = cur_adr_q;
  assign bus.o_saveData = buf_q;
  assign bus.o_saveMask = dirty_q;
  assign bus.o_idle     = (state_q == S_EMPTY) && !flush_pend_q;
endmodule
